lif_synapse: RTL and testbench



---
 rtl/lif_pkg.sv | 14 +
 rtl/lif_syn_decay.sv | 30 +++
 rtl/lif_synapse.sv | 124 ++++++++++++
 tb/tb_lif_synapse.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron/synapse chain.
package lif_pkg;

  localparam int unsigned LIF_WIDTH = 8;
  localparam logic [LIF_WIDTH-1:0] LIF_SAT_MAX = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } lif_state_e;

  typedef logic [1:0] lif_dep_t;

endpackage

// File: rtl/lif_syn_decay.sv
// Combinational next-current rule: decay on tick first, then saturating add of the weight on spike.
module lif_syn_decay #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DECAY_SHIFT = 2
) (
  input  logic [WIDTH-1:0] c,
  input  logic             tick,
  input  logic             spike,
  input  logic [WIDTH-1:0] w_eff,
  output logic [WIDTH-1:0] c_next
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] decayed;
  logic [WIDTH:0]   sum;

  always_comb begin
    d       = c >> DECAY_SHIFT;
    decayed = c;
    if (tick) begin
      // Small currents shed at least one unit per tick so they always reach zero.
      if (d == '0 && c != '0) decayed = c - WIDTH'(1);
      else                    decayed = c - d;
    end
    sum    = {1'b0, decayed} + {1'b0, w_eff};
    c_next = decayed;
    if (spike) c_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/lif_synapse.sv
// Current-based synapse with loadable weight and exponential decay.
// Define SYN_STD_EN to add short-term depression of the effective weight.
module lif_synapse
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH          = LIF_WIDTH,
  parameter int unsigned DECAY_SHIFT    = 2,
  parameter int unsigned PRESCALE       = 4,
  parameter int unsigned RECOVER_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic [WIDTH-1:0] w_data,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [WIDTH-1:0] current_out,
  output logic             active
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  if (PRESCALE < 1 || RECOVER_PERIOD < 1) begin : g_param_check
    $error("lif_synapse: PRESCALE and RECOVER_PERIOD must be at least 1");
  end

  lif_state_e       state_q;
  logic [WIDTH-1:0] w_reg_q;
  logic [WIDTH-1:0] w_eff;
  logic [WIDTH-1:0] current_q;
  logic [WIDTH-1:0] c_next;
  logic [PW-1:0]    presc_q;
  logic             active_q;
  logic             w_ready_q;
  logic             tick;
  logic             load;

  assign tick = (state_q == ACTIVE) && (presc_q == PRESC_MAX);
  assign load = w_valid && w_ready_q;

`ifdef SYN_STD_EN
  localparam int unsigned RW = (RECOVER_PERIOD > 1) ? $clog2(RECOVER_PERIOD) : 1;
  localparam logic [RW-1:0] REC_MAX = RW'(RECOVER_PERIOD - 1);

  lif_dep_t      dep_q;
  logic [RW-1:0] rec_q;

  assign w_eff = w_reg_q >> dep_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dep_q <= '0;
      rec_q <= '0;
    end else begin
      if (spike_in || rec_q == REC_MAX) rec_q <= '0;
      else                              rec_q <= rec_q + 1'b1;
      // A weight load wins over a same-cycle spike: the new weight starts undepressed.
      if (load) begin
        dep_q <= '0;
      end else if (spike_in) begin
        if (dep_q != 2'd3) dep_q <= dep_q + 2'd1;
      end else if (rec_q == REC_MAX && dep_q != '0) begin
        dep_q <= dep_q - 2'd1;
      end
    end
  end
`else
  assign w_eff = w_reg_q;
`endif

  lif_syn_decay #(
    .WIDTH      (WIDTH),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_decay (
    .c     (current_q),
    .tick  (tick),
    .spike (spike_in),
    .w_eff (w_eff),
    .c_next(c_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      current_q <= '0;
      w_reg_q   <= '0;
      presc_q   <= '0;
      active_q  <= 1'b0;
      w_ready_q <= 1'b1;
    end else begin
      current_q <= c_next;
      if (load) w_reg_q <= w_data;
      case (state_q)
        IDLE: begin
          presc_q <= '0;
          if (spike_in && w_eff != '0) begin
            state_q   <= ACTIVE;
            active_q  <= 1'b1;
            w_ready_q <= 1'b0;
          end
        end
        ACTIVE: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (c_next == '0 && !spike_in) begin
            state_q   <= IDLE;
            active_q  <= 1'b0;
            w_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          active_q  <= 1'b0;
          w_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign current_out = current_q;
  assign active      = active_q;
  assign w_ready     = w_ready_q;

endmodule

// File: tb/tb_lif_synapse.sv
// Directed bench for lif_synapse with hand-computed current sequences.
module tb_lif_synapse;
  import lif_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       spike_in;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] current_out;
  logic       active;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lif_synapse dut (
    .clk        (clk),
    .rst        (rst),
    .spike_in   (spike_in),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .current_out(current_out),
    .active     (active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weight(input logic [7:0] w);
    w_data  = w;
    w_valid = 1'b1;
    step();
    w_valid = 1'b0;
  endtask

  task automatic spike_once();
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (active !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    n_checks++;
    if (active !== 1'b0 || current_out !== 8'd0)
      $display("FAIL %s_idle: got active=%0b current=%0d expected active=0 current=0",
               name, active, current_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; spike_in = 1'b0; w_valid = 1'b0; w_data = 8'd0;
    step();
    step();
    n_checks++;
    if (current_out !== 8'd0) $display("FAIL reset_current: got %0d expected 0", current_out);
    else n_pass++;
    n_checks++;
    if (active !== 1'b0) $display("FAIL reset_active: got %0b expected 0", active);
    else n_pass++;
    n_checks++;
    if (w_ready !== 1'b1) $display("FAIL reset_w_ready: got %0b expected 1", w_ready);
    else n_pass++;
    rst = 1'b0;
    spike_once();
    n_checks++;
    if (current_out !== 8'd0 || active !== 1'b0)
      $display("FAIL reset_zero_weight_spike: got current=%0d active=%0b expected 0/0",
               current_out, active);
    else n_pass++;
  endtask

  task automatic test_load_same_cycle();
    w_data = 8'd50; w_valid = 1'b1; spike_in = 1'b1;
    step();
    w_valid = 1'b0; spike_in = 1'b0;
    n_checks++;
    if (current_out !== 8'd0 || active !== 1'b0)
      $display("FAIL same_cycle_old_weight: got current=%0d active=%0b expected 0/0",
               current_out, active);
    else n_pass++;
    spike_once();
    n_checks++;
    if (current_out !== 8'd50) $display("FAIL same_cycle_new_weight: got %0d expected 50", current_out);
    else n_pass++;
    wait_idle("same_cycle");
  endtask

  task automatic test_weight_decay();
    logic [7:0] exp_seq [13] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd75, 8'd75, 8'd75, 8'd75,
                                 8'd57, 8'd57, 8'd57, 8'd57, 8'd43};
    load_weight(8'd100);
    spike_once();
    n_checks++;
    if (active !== 1'b1 || w_ready !== 1'b0)
      $display("FAIL decay_active: got active=%0b w_ready=%0b expected 1/0", active, w_ready);
    else n_pass++;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) step();
      n_checks++;
      if (current_out !== exp_seq[k])
        $display("FAIL decay_seq[%0d]: got %0d expected %0d", k, current_out, exp_seq[k]);
      else n_pass++;
    end
    wait_idle("decay");
  endtask

  task automatic test_saturation();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'd200, LIF_SAT_MAX, LIF_SAT_MAX, LIF_SAT_MAX, 8'd192};
    load_weight(8'd200);
    spike_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) spike_in = 1'b0;
      n_checks++;
      if (current_out !== exp_seq[k])
        $display("FAIL sat_seq[%0d]: got %0d expected %0d", k, current_out, exp_seq[k]);
      else n_pass++;
    end
    spike_in = 1'b0;
    wait_idle("sat");
  endtask

  task automatic test_decay_to_zero();
    logic [7:0] exp_seq [13] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2,
                                 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
    load_weight(8'd3);
    spike_once();
    w_data  = 8'd9;
    w_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 12) w_valid = 1'b0;
      if (k > 0) step();
      n_checks++;
      if (current_out !== exp_seq[k])
        $display("FAIL zero_seq[%0d]: got %0d expected %0d", k, current_out, exp_seq[k]);
      else n_pass++;
    end
    n_checks++;
    if (active !== 1'b0 || w_ready !== 1'b1)
      $display("FAIL zero_exit: got active=%0b w_ready=%0b expected 0/1", active, w_ready);
    else n_pass++;
    spike_once();
    n_checks++;
    if (current_out !== 8'd3)
      $display("FAIL ignored_load: got %0d expected 3", current_out);
    else n_pass++;
    wait_idle("zero");
  endtask

  task automatic test_reset_mid();
    load_weight(8'd150);
    spike_once();
    n_checks++;
    if (current_out !== 8'd150) $display("FAIL mid_pre: got %0d expected 150", current_out);
    else n_pass++;
    rst = 1'b1; spike_in = 1'b1;
    step();
    rst = 1'b0; spike_in = 1'b0;
    n_checks++;
    if (current_out !== 8'd0 || active !== 1'b0 || w_ready !== 1'b1)
      $display("FAIL mid_reset: got current=%0d active=%0b w_ready=%0b expected 0/0/1",
               current_out, active, w_ready);
    else n_pass++;
    spike_once();
    n_checks++;
    if (current_out !== 8'd0 || active !== 1'b0)
      $display("FAIL mid_weight_cleared: got current=%0d active=%0b expected 0/0",
               current_out, active);
    else n_pass++;
  endtask

`ifdef SYN_STD_EN
  task automatic test_std();
    logic [7:0] exp_seq [5] = '{8'd128, 8'd136, 8'd109, 8'd78, 8'd61};
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_weight(8'd128);
    spike_once();
    n_checks++;
    if (current_out !== exp_seq[0]) $display("FAIL std_seq[0]: got %0d expected 128", current_out);
    else n_pass++;
    for (int i = 1; i < 5; i++) begin
      repeat (7) step();
      spike_once();
      n_checks++;
      if (current_out !== exp_seq[i])
        $display("FAIL std_seq[%0d]: got %0d expected %0d", i, current_out, exp_seq[i]);
      else n_pass++;
    end
    repeat (16) step();
    spike_once();
    n_checks++;
    if (current_out !== 8'd53) $display("FAIL std_recover: got %0d expected 53", current_out);
    else n_pass++;
    wait_idle("std");
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_weight(8'd1);
    spike_in = 1'b1;
    repeat (3) step();
    spike_in = 1'b0;
    repeat (2) step();
    n_checks++;
    if (active !== 1'b0) $display("FAIL std_small_idle: got %0b expected 0", active);
    else n_pass++;
    load_weight(8'd128);
    spike_once();
    n_checks++;
    if (current_out !== 8'd128) $display("FAIL std_reload: got %0d expected 128", current_out);
    else n_pass++;
    wait_idle("std_reload");
  endtask
`endif

  initial begin
    test_reset();
    test_load_same_cycle();
    test_weight_decay();
    test_saturation();
    test_decay_to_zero();
    test_reset_mid();
`ifdef SYN_STD_EN
    test_std();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
